ita_accumulator: RTL and testbench

- Accumulates N-lane signed partial dot-product sums over a configurable number of K-tiles.
- Presents each finished N-lane result on a valid/ready output. This is the stage directly upstream of the requantizer, and it drives that stage's result operand.
- Uses a double buffer (accumulate register plus output register), so the next group accumulates while the previous result drains.

---
 rtl/ita_accumulator.sv | 153 +++++++++++++++
 tb/tb_ita_accumulator.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_accumulator.sv
// ita_accumulator: N-lane signed accumulator over a configurable number of
// K-tiles. The accumulate register and the output register form a double
// buffer, so the next group keeps accumulating while the previous result
// waits on out_ready_i. The final tile of a group is summed straight into the
// output register.
module ita_accumulator #(
    parameter int N  = 16,
    parameter int WP = 20,
    parameter int WO = 26,
    parameter int TW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic [TW-1:0]   num_tiles_i,
    input  logic            inp_valid_i,
    output logic            inp_ready_o,
    input  logic [N*WP-1:0] partial_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [N*WO-1:0] result_o,
    output logic [TW-1:0]   tile_cnt_o,
    output logic            ovf_o
);

    localparam logic [TW-1:0] ONE = TW'(1);

    logic [N*WO-1:0]        acc_q, acc_d;
    logic [N*WO-1:0]        result_q, result_d;
    logic [N*WO-1:0]        sum_d;
    logic [TW-1:0]          tile_cnt_q, tile_cnt_d;
    logic [TW-1:0]          len_q, len_d;
    logic [TW-1:0]          eff_len;
    logic                   out_valid_q, out_valid_d;
    logic                   ovf_q, ovf_d;
    logic                   first_tile, last_tile, accept, clamp_any;
    logic signed [WO:0]     lane_wide [N];

    // Sign-extend one partial sum to the result width.
    function automatic logic signed [WO-1:0] sext_part(input logic signed [WP-1:0] p);
        return {{(WO-WP){p[WP-1]}}, p};
    endfunction

    // One guard bit above WO so the overflow is visible before clamping.
    function automatic logic signed [WO:0] wide_add(input logic signed [WO-1:0] a,
                                                     input logic signed [WP-1:0] p);
        logic signed [WO:0] aw;
        logic signed [WO:0] pw;
        aw = {a[WO-1], a};
        pw = {{(WO+1-WP){p[WP-1]}}, p};
        return aw + pw;
    endfunction

    // Clamp a WO+1 bit sum into the signed WO-bit range.
    function automatic logic signed [WO-1:0] sat_wo(input logic signed [WO:0] s);
        if (s[WO] != s[WO-1]) begin
            return s[WO] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
        end
        return s[WO-1:0];
    endfunction

    function automatic logic clamped(input logic signed [WO:0] s);
        return s[WO] ^ s[WO-1];
    endfunction

    // Group length and last-tile detection; a zero length means one tile.
    // On the first tile the live configuration applies, later the captured one.
    always_comb begin
        eff_len    = (num_tiles_i == '0) ? ONE : num_tiles_i;
        first_tile = (tile_cnt_q == '0);
        last_tile  = first_tile ? (eff_len == ONE) : (tile_cnt_q == len_q - ONE);
    end

    // Only a last tile has to wait for the output register to free up.
    assign inp_ready_o = !(last_tile && out_valid_q && !out_ready_i);
    assign accept      = inp_valid_i && inp_ready_o;

    // Per-lane sum: the first tile loads, later tiles add with saturation.
    always_comb begin
        sum_d     = '0;
        clamp_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            lane_wide[i] = wide_add(acc_q[i*WO +: WO], partial_i[i*WP +: WP]);
            if (first_tile) begin
                sum_d[i*WO +: WO] = sext_part(partial_i[i*WP +: WP]);
            end else begin
                sum_d[i*WO +: WO] = sat_wo(lane_wide[i]);
                clamp_any         = clamp_any | clamped(lane_wide[i]);
            end
        end
    end

    // Next-state for counter, config capture, both buffers and sticky overflow.
    always_comb begin
        acc_d       = acc_q;
        result_d    = result_q;
        tile_cnt_d  = tile_cnt_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        if (clear_i) begin
            acc_d       = '0;
            result_d    = '0;
            tile_cnt_d  = '0;
            len_d       = '0;
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            if (out_valid_q && out_ready_i) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                ovf_d = ovf_q | clamp_any;
                if (first_tile) begin
                    len_d = eff_len;
                end
                if (last_tile) begin
                    tile_cnt_d  = '0;
                    result_d    = sum_d;
                    out_valid_d = 1'b1;
                end else begin
                    tile_cnt_d = tile_cnt_q + ONE;
                    acc_d      = sum_d;
                end
            end
        end
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            result_q    <= '0;
            tile_cnt_q  <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            result_q    <= result_d;
            tile_cnt_q  <= tile_cnt_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign tile_cnt_o  = tile_cnt_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_ita_accumulator.sv
// Directed bench for ita_accumulator: a default instance (WO=26) and a
// narrow instance (WO=21) share the same stimulus; the narrow one exercises
// saturation.
module tb_ita_accumulator;

    localparam int N  = 16;
    localparam int WP = 20;
    localparam int WO = 26;
    localparam int WS = 21;
    localparam int TW = 8;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            clear_i = 1'b0;
    logic [TW-1:0]   num_tiles_i = '0;
    logic            inp_valid_i = 1'b0;
    logic [N*WP-1:0] partial_i = '0;
    logic            out_ready_i = 1'b0;

    logic            inp_ready_o, out_valid_o, ovf_o;
    logic [N*WO-1:0] result_o;
    logic [TW-1:0]   tile_cnt_o;

    logic            inp_ready_s, out_valid_s, ovf_s;
    logic [N*WS-1:0] result_s;
    logic [TW-1:0]   tile_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ita_accumulator #(.N(N), .WP(WP), .WO(WO), .TW(TW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .num_tiles_i(num_tiles_i),
        .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o), .partial_i(partial_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
        .tile_cnt_o(tile_cnt_o), .ovf_o(ovf_o)
    );

    ita_accumulator #(.N(N), .WP(WP), .WO(WS), .TW(TW)) dut_s (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .num_tiles_i(num_tiles_i),
        .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_s), .partial_i(partial_i),
        .out_valid_o(out_valid_s), .out_ready_i(out_ready_i), .result_o(result_s),
        .tile_cnt_o(tile_cnt_s), .ovf_o(ovf_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < N; i++) partial_i[i*WP +: WP] = v[WP-1:0];
    endtask

    function automatic logic lanes_eq(input logic [N*WO-1:0] r, input int v);
        for (int i = 0; i < N; i++) begin
            if ($signed(r[i*WO +: WO]) != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int lane0(input logic [N*WO-1:0] r);
        return int'($signed(r[WO-1:0]));
    endfunction

    task automatic test_reset();
        #2;
        n_checks++;
        if (out_valid_o !== 1'b0 || tile_cnt_o !== '0 || ovf_o !== 1'b0 || result_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got vld=%b cnt=%0d ovf=%b res0=%0d expected all 0",
                     out_valid_o, tile_cnt_o, ovf_o, lane0(result_o));
        end
        n_checks++;
        if (inp_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", inp_ready_o);
        end
        #1 rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_group4();
        int vals[4] = '{10, -3, 7, 100};
        int cnts[4] = '{1, 2, 3, 0};
        num_tiles_i = 8'd4;
        out_ready_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            set_all(vals[t]);
            inp_valid_i = 1'b1;
            n_checks++;
            if (out_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL g4_early_valid tile %0d: got %b expected 0", t, out_valid_o);
            end
            tick();
            n_checks++;
            if (tile_cnt_o !== TW'(cnts[t])) begin
                n_fail++;
                $display("FAIL g4_tile_cnt tile %0d: got %0d expected %0d", t, tile_cnt_o, cnts[t]);
            end
        end
        inp_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b1 || !lanes_eq(result_o, 114) || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL g4_result: got vld=%b res0=%0d ovf=%b expected vld=1 res=114 ovf=0",
                     out_valid_o, lane0(result_o), ovf_o);
        end
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL g4_one_cycle_valid: got %b expected 0", out_valid_o);
        end
    endtask

    task automatic test_backpressure();
        num_tiles_i = 8'd2;
        out_ready_i = 1'b0;
        inp_valid_i = 1'b1;
        set_all(5);
        tick();
        tick();
        set_all(1);
        n_checks++;
        if (out_valid_o !== 1'b1 || !lanes_eq(result_o, 10)) begin
            n_fail++;
            $display("FAIL bp_groupA: got vld=%b res0=%0d expected vld=1 res=10", out_valid_o, lane0(result_o));
        end
        n_checks++;
        if (inp_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_tile_ready: got %b expected 1", inp_ready_o);
        end
        tick();
        n_checks++;
        if (tile_cnt_o !== 8'd1 || inp_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: got cnt=%0d ready=%b expected cnt=1 ready=0", tile_cnt_o, inp_ready_o);
        end
        tick();
        n_checks++;
        if (tile_cnt_o !== 8'd1 || out_valid_o !== 1'b1 || !lanes_eq(result_o, 10) || inp_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got cnt=%0d vld=%b res0=%0d ready=%b expected 1,1,10,0",
                     tile_cnt_o, out_valid_o, lane0(result_o), inp_ready_o);
        end
        out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (inp_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_follows_out_ready: got %b expected 1", inp_ready_o);
        end
        tick();
        out_ready_i = 1'b0;
        inp_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b1 || !lanes_eq(result_o, 2) || tile_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL bp_groupB: got vld=%b res0=%0d cnt=%0d expected 1,2,0",
                     out_valid_o, lane0(result_o), tile_cnt_o);
        end
        out_ready_i = 1'b1;
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got %b expected 0", out_valid_o);
        end
    endtask

    task automatic test_saturation();
        int l0;
        int l1;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        num_tiles_i = 8'd3;
        out_ready_i = 1'b1;
        partial_i = '0;
        partial_i[0*WP +: WP] = 20'sh7FFFF;
        partial_i[1*WP +: WP] = 20'sh80000;
        inp_valid_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ovf_s !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_exact_limit_no_ovf: got %b expected 0", ovf_s);
        end
        tick();
        inp_valid_i = 1'b0;
        l0 = int'($signed(result_s[0*WS +: WS]));
        l1 = int'($signed(result_s[1*WS +: WS]));
        n_checks++;
        if (out_valid_s !== 1'b1 || l0 != 1048575 || l1 != -1048576) begin
            n_fail++;
            $display("FAIL sat_clamp: got vld=%b l0=%0d l1=%0d expected 1,1048575,-1048576", out_valid_s, l0, l1);
        end
        n_checks++;
        if (ovf_s !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_ovf_set: got %b expected 1", ovf_s);
        end
        n_checks++;
        if (lane0(result_o) != 1572861 || int'($signed(result_o[WO +: WO])) != -1572864 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_wide_no_clamp: got l0=%0d ovf=%b expected 1572861,0", lane0(result_o), ovf_o);
        end
        tick();
        tick();
        n_checks++;
        if (ovf_s !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_ovf_sticky: got %b expected 1", ovf_s);
        end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_checks++;
        if (ovf_s !== 1'b0 || result_s !== '0) begin
            n_fail++;
            $display("FAIL sat_clear: got ovf=%b expected 0", ovf_s);
        end
    endtask

    task automatic test_single_tile();
        num_tiles_i = 8'd0;
        out_ready_i = 1'b1;
        inp_valid_i = 1'b1;
        for (int v = 0; v < 8; v++) begin
            set_all(v);
            n_checks++;
            if (inp_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL single_ready %0d: got %b expected 1", v, inp_ready_o);
            end
            tick();
            n_checks++;
            if (out_valid_o !== 1'b1 || !lanes_eq(result_o, v) || tile_cnt_o !== 8'd0) begin
                n_fail++;
                $display("FAIL single_result %0d: got vld=%b res0=%0d cnt=%0d expected 1,%0d,0",
                         v, out_valid_o, lane0(result_o), tile_cnt_o, v);
            end
        end
        inp_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_config_and_clear();
        num_tiles_i = 8'd3;
        out_ready_i = 1'b0;
        inp_valid_i = 1'b1;
        set_all(1);
        tick();
        num_tiles_i = 8'd1;
        set_all(2);
        tick();
        n_checks++;
        if (tile_cnt_o !== 8'd2 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_midgroup: got cnt=%0d vld=%b expected 2,0", tile_cnt_o, out_valid_o);
        end
        set_all(3);
        tick();
        n_checks++;
        if (out_valid_o !== 1'b1 || !lanes_eq(result_o, 6) || tile_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL cfg_group_end: got vld=%b res0=%0d cnt=%0d expected 1,6,0",
                     out_valid_o, lane0(result_o), tile_cnt_o);
        end
        num_tiles_i = 8'd3;
        set_all(4);
        tick();
        clear_i = 1'b1;
        set_all(50);
        tick();
        clear_i = 1'b0;
        n_checks++;
        if (tile_cnt_o !== 8'd0 || out_valid_o !== 1'b0 || result_o !== '0) begin
            n_fail++;
            $display("FAIL clear_flush: got cnt=%0d vld=%b res0=%0d expected 0,0,0",
                     tile_cnt_o, out_valid_o, lane0(result_o));
        end
        out_ready_i = 1'b1;
        set_all(1);
        tick();
        tick();
        tick();
        inp_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b1 || !lanes_eq(result_o, 3)) begin
            n_fail++;
            $display("FAIL clear_fresh_group: got vld=%b res0=%0d expected 1,3", out_valid_o, lane0(result_o));
        end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        num_tiles_i = 8'd1;
        inp_valid_i = 1'b1;
        set_all(9);
        tick();
        num_tiles_i = 8'd3;
        set_all(2);
        tick();
        tick();
        inp_valid_i = 1'b0;
        n_checks++;
        if (tile_cnt_o !== 8'd2 || out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_precondition: got cnt=%0d vld=%b expected 2,1", tile_cnt_o, out_valid_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (tile_cnt_o !== '0 || out_valid_o !== 1'b0 || result_o !== '0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got cnt=%0d vld=%b res0=%0d ovf=%b expected all 0",
                     tile_cnt_o, out_valid_o, lane0(result_o), ovf_o);
        end
        #1 rst_ni = 1'b1;
        out_ready_i = 1'b1;
        num_tiles_i = 8'd2;
        inp_valid_i = 1'b1;
        set_all(7);
        tick();
        set_all(8);
        tick();
        inp_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b1 || !lanes_eq(result_o, 15)) begin
            n_fail++;
            $display("FAIL arst_first_loads: got vld=%b res0=%0d expected 1,15", out_valid_o, lane0(result_o));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_group4();
        test_backpressure();
        test_saturation();
        test_single_tile();
        test_config_and_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
